instr_ram_prefetch: RTL and testbench

// - Initiator for the instruction RAM port (en/addr/wdata/we/be -> rdata, fixed 1-cycle read latency, no stall).
// - Sits between the core fetch stage and the instruction RAM (incl. boot ROM region).
// - Issues sequential word reads from a program counter and buffers the returned words in a small FIFO.
// - Presents words to the core over a valid/ready handshake; a branch flushes the buffer and restarts at a new address.

---
 rtl/instr_ram_prefetch_pkg.sv | 18 +
 rtl/instr_ram_prefetch_if.sv | 34 +++
 rtl/instr_ram_prefetch_fifo.sv | 64 ++++++
 rtl/instr_ram_prefetch.sv | 133 +++++++++++++
 tb/tb_instr_ram_prefetch.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_ram_prefetch_pkg.sv
// Shared types and constants for the instruction RAM prefetcher.
// The fetch entry struct depends on ADDR_WIDTH, so it is declared inside the top module.
package instr_fetch_pkg;

    localparam int         INSTR_WIDTH = 32;
    localparam logic [3:0] MEM_BE_ALL  = 4'hF;

    typedef enum logic {
        IDLE,
        FETCH
    } fetch_state_t;

    // Byte address of the word that follows a, wrapping at the top of the address space.
    function automatic logic [31:0] next_word_addr(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/instr_ram_prefetch_if.sv
// Bundle of fetch-side handshake and RAM port signals.
// The master modport is the prefetcher; the slave modport is the core plus RAM.
interface instr_ram_prefetch_if #(
    parameter int ADDR_WIDTH = 17
);
    import instr_fetch_pkg::*;

    logic                   branch_i;
    logic [ADDR_WIDTH-1:0]  branch_addr_i;
    logic                   fetch_valid_o;
    logic                   fetch_ready_i;
    logic [INSTR_WIDTH-1:0] fetch_rdata_o;
    logic [ADDR_WIDTH-1:0]  fetch_addr_o;
    logic                   busy_o;
    logic                   mem_en_o;
    logic [ADDR_WIDTH-1:0]  mem_addr_o;
    logic [INSTR_WIDTH-1:0] mem_wdata_o;
    logic                   mem_we_o;
    logic [3:0]             mem_be_o;
    logic [INSTR_WIDTH-1:0] mem_rdata_i;

    modport master (
        input  branch_i, branch_addr_i, fetch_ready_i, mem_rdata_i,
        output fetch_valid_o, fetch_rdata_o, fetch_addr_o, busy_o,
               mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o
    );

    modport slave (
        output branch_i, branch_addr_i, fetch_ready_i, mem_rdata_i,
        input  fetch_valid_o, fetch_rdata_o, fetch_addr_o, busy_o,
               mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o
    );

endinterface

// File: rtl/instr_ram_prefetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush; head word shown combinationally from storage.
// Latency: push visible at the head one cycle later; no backpressure, caller must never push when full.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == (PW+1)'(DEPTH));
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    // Flush wins over both push and pop so a branch leaves the FIFO truly empty.
    assign w_push = push_i & ~flush_i;
    assign w_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_push |-> !full_o);

endmodule

// File: rtl/instr_ram_prefetch.sv
// Sequential instruction prefetcher: issues word reads from a PC into a small FIFO, restarts on branch.
// Latency: branch -> valid two cycles later; requests throttle so FIFO plus in-flight read never exceeds depth.
module instr_ram_prefetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_ram_prefetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] rdata;
        logic [ADDR_WIDTH-1:0]  addr;
    } fetch_entry_t;

    localparam int EW = $bits(fetch_entry_t);

    fetch_state_t          r_state;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_inflight;

    logic [ADDR_WIDTH-1:0] w_branch_addr;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_occ;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_req;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;
    logic [EW-1:0]         w_fifo_din;
    logic [EW-1:0]         w_fifo_dout;
    logic                  w_unused_ok;

    assign w_branch_addr = {bus.branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_req_addr    = bus.branch_i ? w_branch_addr : r_pc;
    assign w_next_pc     = ADDR_WIDTH'(next_word_addr(32'(w_req_addr)));

    // A branch masks valid, so a coincident ready never pops a stale word.
    assign w_valid = ~w_empty & ~bus.branch_i;
    assign w_pop   = w_valid & bus.fetch_ready_i;

    // The response landing in a branch cycle belongs to the old stream and is dropped.
    assign w_push = r_inflight & ~bus.branch_i;
    assign w_occ  = w_count + CW'(r_inflight);

    always_comb begin
        w_req = 1'b0;
        if (bus.branch_i) begin
            w_req = 1'b1;
        end else if (r_state == FETCH) begin
            w_req = (w_occ < CW'(FIFO_DEPTH)) ||
                    ((w_occ == CW'(FIFO_DEPTH)) && w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_pc       <= '0;
            r_req_addr <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.branch_i) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_state <= FETCH;
                    r_busy  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            r_inflight <= w_req;
            if (w_req) begin
                r_pc       <= w_next_pc;
                r_req_addr <= w_req_addr;
            end
        end
    end

    assign w_push_entry = '{rdata: bus.mem_rdata_i, addr: r_req_addr};
    assign w_fifo_din   = w_push_entry;
    assign w_head       = fetch_entry_t'(w_fifo_dout);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.branch_i),
        .push_i  (w_push),
        .data_i  (w_fifo_din),
        .pop_i   (w_pop),
        .data_o  (w_fifo_dout),
        .empty_o (w_empty),
        .full_o  (w_full),
        .count_o (w_count)
    );

    assign bus.fetch_valid_o = w_valid;
    assign bus.fetch_rdata_o = w_head.rdata;
    assign bus.fetch_addr_o  = w_head.addr;
    assign bus.busy_o        = r_busy;

    assign bus.mem_en_o    = w_req;
    assign bus.mem_addr_o  = w_req_addr;
    assign bus.mem_wdata_o = '0;
    assign bus.mem_we_o    = 1'b0;
    assign bus.mem_be_o    = MEM_BE_ALL;

    assign w_unused_ok = ^{w_full, bus.branch_addr_i[1:0]};

endmodule

// File: tb/tb_instr_ram_prefetch.sv
// Directed bench for instr_ram_prefetch with a 1-cycle-latency RAM model.
module tb_instr_ram_prefetch;

    localparam int AW = 17;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    instr_ram_prefetch_if #(.ADDR_WIDTH(AW)) bus ();

    instr_ram_prefetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [AW-1:0] a);
        return 32'hC0DE0000 ^ {15'h0, a};
    endfunction

    // RAM: data for the address requested last cycle; garbage when no request was made.
    always @(posedge clk) begin
        bus.mem_rdata_i <= bus.mem_en_o ? mdata(bus.mem_addr_o) : 32'hBAD0BAD0;
    end

    task automatic test_reset;
        rst_n = 1'b0;
        bus.branch_i = 1'b0;
        bus.branch_addr_i = '0;
        bus.fetch_ready_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.mem_en_o, bus.busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/en/busy=%b want 000",
                     {bus.fetch_valid_o, bus.mem_en_o, bus.busy_o});
        end
        n_cmp++;
        if ({bus.fetch_rdata_o, bus.fetch_addr_o, bus.mem_addr_o} !== {32'h0, 17'h0, 17'h0}) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%h faddr=%h maddr=%h want 0",
                     bus.fetch_rdata_o, bus.fetch_addr_o, bus.mem_addr_o);
        end
        n_cmp++;
        if ({bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o} !== {1'b0, 4'hF, 32'h0}) begin
            n_err++;
            $display("FAIL const_outs: got we=%b be=%h wdata=%h want 0/F/0",
                     bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({bus.fetch_valid_o, bus.mem_en_o, bus.busy_o} !== 3'b000) begin
                n_err++;
                $display("FAIL idle_c%0d: got valid/en/busy=%b want 000", k,
                         {bus.fetch_valid_o, bus.mem_en_o, bus.busy_o});
            end
        end
    endtask

    task automatic test_sequential;
        logic [AW-1:0] ea;
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00100;
        bus.fetch_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({bus.mem_en_o, bus.mem_addr_o, bus.fetch_valid_o} !== {1'b1, 17'h00100, 1'b0}) begin
            n_err++;
            $display("FAIL seq_branch_req: got en=%b addr=%h valid=%b want 1/00100/0",
                     bus.mem_en_o, bus.mem_addr_o, bus.fetch_valid_o);
        end
        @(negedge clk);
        bus.branch_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_en_o, bus.mem_addr_o, bus.fetch_valid_o, bus.busy_o} !== {1'b1, 17'h00104, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL seq_c1: got en=%b addr=%h valid=%b busy=%b want 1/00104/0/1",
                     bus.mem_en_o, bus.mem_addr_o, bus.fetch_valid_o, bus.busy_o);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            ea = 17'h00100 + 17'(4 * k);
            n_cmp++;
            if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o} !== {1'b1, ea, mdata(ea)}) begin
                n_err++;
                $display("FAIL seq_word%0d: got valid=%b addr=%h data=%h want 1/%h/%h", k,
                         bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, ea, mdata(ea));
            end
            n_cmp++;
            if ({bus.mem_en_o, bus.mem_addr_o} !== {1'b1, ea + 17'h8}) begin
                n_err++;
                $display("FAIL seq_req%0d: got en=%b addr=%h want 1/%h", k,
                         bus.mem_en_o, bus.mem_addr_o, ea + 17'h8);
            end
        end
    endtask

    task automatic test_full_backpressure;
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00203;
        bus.fetch_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.branch_i = 1'b0;
            end
            #1;
            n_cmp++;
            if (k < 4 && {bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 17'h00200 + 17'(4 * k)}) begin
                n_err++;
                $display("FAIL full_req%0d: got en=%b addr=%h want 1/%h", k,
                         bus.mem_en_o, bus.mem_addr_o, 17'h00200 + 17'(4 * k));
            end else if (k >= 4 && bus.mem_en_o !== 1'b0) begin
                n_err++;
                $display("FAIL full_noreq%0d: got en=%b want 0", k, bus.mem_en_o);
            end
            if (k >= 2) begin
                n_cmp++;
                if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o} !== {1'b1, 17'h00200, mdata(17'h00200)}) begin
                    n_err++;
                    $display("FAIL full_hold%0d: got valid=%b addr=%h data=%h want 1/00200/%h", k,
                             bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, mdata(17'h00200));
                end
            end
        end
        @(negedge clk);
        bus.fetch_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 17'h00200, 1'b1, 17'h00210}) begin
            n_err++;
            $display("FAIL full_pop_req: got valid=%b faddr=%h en=%b maddr=%h want 1/00200/1/00210",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o, bus.mem_addr_o);
        end
        @(negedge clk);
        bus.fetch_ready_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o} !== {1'b1, 17'h00204, 1'b0}) begin
            n_err++;
            $display("FAIL full_after_pop: got valid=%b faddr=%h en=%b want 1/00204/0",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o);
        end
    endtask

    task automatic test_branch_flush;
        logic [AW-1:0] ea;
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00280;
        bus.fetch_ready_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus.branch_i = 1'b0;
        end
        // Three words buffered and the 0x28C read returning this cycle.
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00300;
        bus.fetch_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.mem_en_o, bus.mem_addr_o} !== {1'b0, 1'b1, 17'h00300}) begin
            n_err++;
            $display("FAIL flush_branch: got valid=%b en=%b addr=%h want 0/1/00300",
                     bus.fetch_valid_o, bus.mem_en_o, bus.mem_addr_o);
        end
        @(negedge clk);
        bus.branch_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.mem_addr_o} !== {1'b0, 17'h00304}) begin
            n_err++;
            $display("FAIL flush_empty: got valid=%b maddr=%h want 0/00304",
                     bus.fetch_valid_o, bus.mem_addr_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            ea = 17'h00300 + 17'(4 * k);
            n_cmp++;
            if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o} !== {1'b1, ea, mdata(ea)}) begin
                n_err++;
                $display("FAIL flush_word%0d: got valid=%b addr=%h data=%h want 1/%h/%h", k,
                         bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, ea, mdata(ea));
            end
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h1FFFC;
        bus.fetch_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_addr_o !== 17'h1FFFC) begin
            n_err++;
            $display("FAIL wrap_req0: got addr=%h want 1fffc", bus.mem_addr_o);
        end
        @(negedge clk);
        bus.branch_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 17'h00000}) begin
            n_err++;
            $display("FAIL wrap_req1: got en=%b addr=%h want 1/00000", bus.mem_en_o, bus.mem_addr_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, bus.mem_addr_o} !==
            {1'b1, 17'h1FFFC, mdata(17'h1FFFC), 17'h00004}) begin
            n_err++;
            $display("FAIL wrap_word0: got valid=%b faddr=%h data=%h maddr=%h want 1/1fffc/%h/00004",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, bus.mem_addr_o, mdata(17'h1FFFC));
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o} !== {1'b1, 17'h00000, mdata(17'h00000)}) begin
            n_err++;
            $display("FAIL wrap_word1: got valid=%b addr=%h data=%h want 1/00000/%h",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, mdata(17'h00000));
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00400;
        bus.fetch_ready_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bus.branch_i = 1'b0;
        end
        bus.fetch_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 17'h00400, 1'b1, 17'h00410}) begin
            n_err++;
            $display("FAIL rst_pre: got valid=%b faddr=%h en=%b maddr=%h want 1/00400/1/00410",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.mem_en_o, bus.mem_addr_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.mem_en_o, bus.busy_o, bus.fetch_addr_o, bus.mem_addr_o, bus.fetch_rdata_o} !==
            {1'b0, 1'b0, 1'b0, 17'h0, 17'h0, 32'h0}) begin
            n_err++;
            $display("FAIL rst_async: got valid=%b en=%b busy=%b faddr=%h maddr=%h data=%h want all 0",
                     bus.fetch_valid_o, bus.mem_en_o, bus.busy_o, bus.fetch_addr_o, bus.mem_addr_o, bus.fetch_rdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({bus.fetch_valid_o, bus.mem_en_o, bus.busy_o} !== 3'b000) begin
                n_err++;
                $display("FAIL rst_idle_c%0d: got valid/en/busy=%b want 000", k,
                         {bus.fetch_valid_o, bus.mem_en_o, bus.busy_o});
            end
        end
        @(negedge clk);
        bus.branch_i = 1'b1;
        bus.branch_addr_i = 17'h00500;
        #1;
        n_cmp++;
        if ({bus.mem_en_o, bus.mem_addr_o} !== {1'b1, 17'h00500}) begin
            n_err++;
            $display("FAIL rst_rebranch: got en=%b addr=%h want 1/00500", bus.mem_en_o, bus.mem_addr_o);
        end
        @(negedge clk);
        bus.branch_i = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o} !== {1'b1, 17'h00500, mdata(17'h00500)}) begin
            n_err++;
            $display("FAIL rst_reword: got valid=%b addr=%h data=%h want 1/00500/%h",
                     bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_rdata_o, mdata(17'h00500));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_backpressure();
        test_branch_flush();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
